// File: rtl/ctx_stack_sequencer.sv
// Context save/restore sequencer: streams a fixed register-file frame onto the
// core's hardware stack and pops it back in reverse order, aborting on overflow/underflow.
module ctx_stack_sequencer #(
  parameter  int FRAME_WORDS = 10,
  localparam int AW = $clog2(FRAME_WORDS),
  localparam int CW = $clog2(FRAME_WORDS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          save_req,
  input  logic          restore_req,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [CW-1:0] xfer_count,
  output logic [AW-1:0] ctx_raddr,
  input  logic [31:0]   ctx_rdata,
  output logic          ctx_we,
  output logic [AW-1:0] ctx_waddr,
  output logic [31:0]   ctx_wdata,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [31:0]   stk_wdata,
  input  logic [31:0]   stk_rdata,
  input  logic          stk_overflow,
  input  logic          stk_underflow
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SAVE     = 3'd1;
  localparam logic [2:0] ST_SAVE_CHK = 3'd2;
  localparam logic [2:0] ST_REST     = 3'd3;
  localparam logic [2:0] ST_REST_WB  = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;

  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_WORDS - 1);
  localparam logic [CW-1:0] FRAME_CW = CW'(FRAME_WORDS);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] xfer_q, xfer_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [CW-1:0] rest_widx;

  // Pop k returns word FRAME_WORDS-1-k; its data is written one cycle later,
  // when idx has already advanced to k+1.
  assign rest_widx = FRAME_CW - idx_q;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    xfer_d     = xfer_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    ctx_raddr  = '0;
    ctx_we     = 1'b0;
    ctx_waddr  = '0;
    ctx_wdata  = '0;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_wdata  = '0;

    case (state_q)
      ST_IDLE: begin
        if (save_req || restore_req) begin
          idx_d      = '0;
          xfer_d     = '0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          state_d    = save_req ? ST_SAVE : ST_REST;
        end
      end

      ST_SAVE: begin
        ctx_raddr = idx_q[AW-1:0];
        stk_wdata = ctx_rdata;
        stk_push  = !stk_overflow;
        if (stk_overflow) begin
          err_d      = 1'b1;
          err_code_d = ERR_OVF;
          state_d    = ST_DONE;
        end else begin
          // The flag is one cycle late, so only pushes 0..idx-1 are confirmed.
          xfer_d = idx_q;
          if (idx_q == LAST_IDX) state_d = ST_SAVE_CHK;
          else                   idx_d   = idx_q + CW'(1);
        end
      end

      ST_SAVE_CHK: begin
        if (stk_overflow) begin
          err_d      = 1'b1;
          err_code_d = ERR_OVF;
          xfer_d     = LAST_IDX;
        end else begin
          xfer_d = FRAME_CW;
        end
        state_d = ST_DONE;
      end

      ST_REST: begin
        stk_pop = !stk_underflow;
        if (stk_underflow) begin
          err_d      = 1'b1;
          err_code_d = ERR_UNF;
          state_d    = ST_DONE;
        end else begin
          if (idx_q != '0) begin
            ctx_we    = 1'b1;
            ctx_waddr = rest_widx[AW-1:0];
            ctx_wdata = stk_rdata;
            xfer_d    = xfer_q + CW'(1);
          end
          if (idx_q == LAST_IDX) state_d = ST_REST_WB;
          else                   idx_d   = idx_q + CW'(1);
        end
      end

      ST_REST_WB: begin
        if (!stk_underflow) begin
          ctx_we    = 1'b1;
          ctx_waddr = '0;
          ctx_wdata = stk_rdata;
          xfer_d    = xfer_q + CW'(1);
        end else begin
          err_d      = 1'b1;
          err_code_d = ERR_UNF;
        end
        state_d = ST_DONE;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      xfer_q     <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      xfer_q     <= xfer_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign busy       = (state_q == ST_SAVE) || (state_q == ST_SAVE_CHK) ||
                      (state_q == ST_REST) || (state_q == ST_REST_WB);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign xfer_count = xfer_q;

endmodule

// File: tb/tb_ctx_stack_sequencer.sv
// Directed bench for ctx_stack_sequencer: register-file and stack models plus
// scoreboard queues of expected pushes and register-file writes.
module tb_ctx_stack_sequencer;

  localparam int FW = 10;
  localparam int AW = 4;
  localparam int CW = 4;
  localparam logic [31:0] PAT = 32'hA000_0000;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk;
  logic          rst_n;
  logic          save_req;
  logic          restore_req;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [CW-1:0] xfer_count;
  logic [AW-1:0] ctx_raddr;
  logic [31:0]   ctx_rdata;
  logic          ctx_we;
  logic [AW-1:0] ctx_waddr;
  logic [31:0]   ctx_wdata;
  logic          stk_push;
  logic          stk_pop;
  logic [31:0]   stk_wdata;
  logic [31:0]   stk_rdata = '0;
  logic          stk_overflow = 1'b0;
  logic          stk_underflow = 1'b0;

  ctx_stack_sequencer #(.FRAME_WORDS(FW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .save_req     (save_req),
    .restore_req  (restore_req),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_code     (err_code),
    .xfer_count   (xfer_count),
    .ctx_raddr    (ctx_raddr),
    .ctx_rdata    (ctx_rdata),
    .ctx_we       (ctx_we),
    .ctx_waddr    (ctx_waddr),
    .ctx_wdata    (ctx_wdata),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_wdata    (stk_wdata),
    .stk_rdata    (stk_rdata),
    .stk_overflow (stk_overflow),
    .stk_underflow(stk_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int e_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stack controller model: registered one-cycle overflow/underflow flags.
  logic [31:0] stk_mem [0:63];
  int          sp = 0;
  int          cap = 32;
  logic        stk_clear = 1'b0;

  always @(posedge clk) begin
    if (stk_clear) begin
      sp            <= 0;
      stk_overflow  <= 1'b0;
      stk_underflow <= 1'b0;
    end else begin
      stk_overflow  <= 1'b0;
      stk_underflow <= 1'b0;
      if (stk_push) begin
        if (sp < cap) begin
          stk_mem[sp] <= stk_wdata;
          sp          <= sp + 1;
        end else begin
          stk_overflow <= 1'b1;
        end
      end
      if (stk_pop) begin
        if (sp > 0) begin
          stk_rdata <= stk_mem[sp-1];
          sp        <= sp - 1;
        end else begin
          stk_underflow <= 1'b1;
        end
      end
    end
  end

  // Register-file model: combinational read, clocked write, bench load/clear.
  logic [31:0] rf [0:15];
  logic [1:0]  rf_cmd = 2'd0;

  assign ctx_rdata = rf[ctx_raddr];

  always @(posedge clk) begin
    if (rf_cmd == 2'd1) begin
      for (int i = 0; i < 16; i++) rf[i] <= PAT + 32'(i);
    end else if (rf_cmd == 2'd2) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (ctx_we) begin
      rf[ctx_waddr] <= ctx_wdata;
    end
  end

  // Scoreboard: expected pushes / writes are queued with the stimulus and
  // retired as the DUT presents them.
  logic [31:0] exp_push [$];
  wr_t         exp_wr   [$];
  wr_t         wr_exp_item;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stk_push || stk_pop) check("push_pop_excl", {31'b0, stk_push & stk_pop}, 32'd0);
      if (busy && stk_overflow)  check("push_gated_by_ovf", {31'b0, stk_push}, 32'd0);
      if (busy && stk_underflow) check("pop_gated_by_unf", {31'b0, stk_pop}, 32'd0);
      if (stk_push) begin
        if (exp_push.size() == 0) check("push_unexpected", 32'd1, 32'd0);
        else                      check("push_data", stk_wdata, exp_push.pop_front());
      end
      if (ctx_we) begin
        if (exp_wr.size() == 0) begin
          check("wr_unexpected", 32'd1, 32'd0);
        end else begin
          wr_exp_item = exp_wr.pop_front();
          check("wr_addr", {28'b0, ctx_waddr}, {28'b0, wr_exp_item.addr});
          check("wr_data", ctx_wdata, wr_exp_item.data);
        end
      end
    end
  end

  int d_rel, n_push, n_pop, n_wr, first_pop, first_wr, last_wr;

  task automatic start_op(input logic s, input logic r);
    @(negedge clk);
    save_req    = s;
    restore_req = r;
    @(posedge clk);
    #1;
    save_req    = 1'b0;
    restore_req = 1'b0;
    e_cyc       = cyc;
  endtask

  // Cycle E+rel is the rel-th cycle after the accepting edge E.
  task automatic wait_done(input int pulse_at);
    int rel;
    d_rel = -1; n_push = 0; n_pop = 0; n_wr = 0;
    first_pop = -1; first_wr = -1; last_wr = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      rel = cyc - e_cyc + 1;
      restore_req = (rel == pulse_at);
      if (stk_push) n_push++;
      if (stk_pop) begin
        n_pop++;
        if (first_pop < 0) first_pop = rel;
      end
      if (ctx_we) begin
        n_wr++;
        if (first_wr < 0) first_wr = rel;
        last_wr = rel;
      end
      if (done) begin
        d_rel = rel;
        break;
      end
    end
    restore_req = 1'b0;
    if (d_rel < 0) check("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic load_exp_push(input int n);
    for (int i = 0; i < n; i++) exp_push.push_back(PAT + 32'(i));
  endtask

  task automatic stack_reset(input int new_cap);
    @(negedge clk);
    cap       = new_cap;
    stk_clear = 1'b1;
    @(negedge clk);
    stk_clear = 1'b0;
  endtask

  task automatic rf_op(input logic [1:0] cmd);
    @(negedge clk);
    rf_cmd = cmd;
    @(negedge clk);
    rf_cmd = 2'd0;
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_busy"},       {31'b0, busy},       32'd0);
    check({pfx, "_done"},       {31'b0, done},       32'd0);
    check({pfx, "_err"},        {31'b0, err},        32'd0);
    check({pfx, "_err_code"},   {30'b0, err_code},   32'd0);
    check({pfx, "_xfer"},       {28'b0, xfer_count}, 32'd0);
    check({pfx, "_push"},       {31'b0, stk_push},   32'd0);
    check({pfx, "_pop"},        {31'b0, stk_pop},    32'd0);
    check({pfx, "_we"},         {31'b0, ctx_we},     32'd0);
    check({pfx, "_raddr"},      {28'b0, ctx_raddr},  32'd0);
    check({pfx, "_waddr"},      {28'b0, ctx_waddr},  32'd0);
    check({pfx, "_wdata"},      ctx_wdata,           32'd0);
    check({pfx, "_stk_wdata"},  stk_wdata,           32'd0);
  endtask

  task automatic check_result(input string pfx, input int exp_rel, input logic e,
                              input logic [1:0] code, input int xfer);
    check({pfx, "_done_cycle"}, 32'(d_rel), 32'(exp_rel));
    check({pfx, "_err"},        {31'b0, err},        {31'b0, e});
    check({pfx, "_err_code"},   {30'b0, err_code},   {30'b0, code});
    check({pfx, "_xfer"},       {28'b0, xfer_count}, 32'(xfer));
    @(negedge clk);
    check({pfx, "_done_once"},  {31'b0, done},       32'd0);
    check({pfx, "_push_q_empty"}, 32'(exp_push.size()), 32'd0);
    check({pfx, "_wr_q_empty"},   32'(exp_wr.size()),   32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    save_req    = 1'b0;
    restore_req = 1'b0;
    stack_reset(32);
    rf_op(2'd1);
    check_quiet("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet("idle_after_reset");

    // Full save: ten pushes of the register-file pattern.
    load_exp_push(FW);
    start_op(1'b1, 1'b0);
    wait_done(-1);
    check("save_n_push", 32'(n_push), 32'(FW));
    check("save_sp", 32'(sp), 32'(FW));
    check_result("save", FW + 2, 1'b0, 2'b00, FW);

    // Full restore into a cleared register file.
    rf_op(2'd2);
    for (int i = FW - 1; i >= 0; i--) exp_wr.push_back('{addr: AW'(i), data: PAT + 32'(i)});
    start_op(1'b0, 1'b1);
    wait_done(-1);
    check("rest_first_pop", 32'(first_pop), 32'd1);
    check("rest_first_wr", 32'(first_wr), 32'd2);
    check("rest_last_wr", 32'(last_wr), 32'(FW + 1));
    check("rest_n_wr", 32'(n_wr), 32'(FW));
    check_result("rest", FW + 2, 1'b0, 2'b00, FW);
    for (int i = 0; i < FW; i++) check("rest_rf", rf[i], PAT + 32'(i));

    // Save into a stack with three free slots: fourth push is rejected.
    stack_reset(3);
    load_exp_push(4);
    start_op(1'b1, 1'b0);
    wait_done(-1);
    check("ovf_sp", 32'(sp), 32'd3);
    check_result("ovf", 6, 1'b1, 2'b01, 3);
    repeat (3) @(negedge clk);
    check("ovf_err_held", {31'b0, err}, 32'd1);
    check("ovf_code_held", {30'b0, err_code}, 32'd1);

    // Save with four free slots; acceptance clears the previous error.
    stack_reset(4);
    load_exp_push(5);
    start_op(1'b1, 1'b0);
    check("accept_err_clr", {31'b0, err}, 32'd0);
    check("accept_code_clr", {30'b0, err_code}, 32'd0);
    check("accept_xfer_clr", {28'b0, xfer_count}, 32'd0);
    wait_done(-1);
    check_result("ovf4", 7, 1'b1, 2'b01, 4);

    // Restore with four words on the stack: writes 9..6, then underflow.
    rf_op(2'd2);
    for (int i = 0; i < 4; i++) exp_wr.push_back('{addr: AW'(FW - 1 - i), data: PAT + 32'(3 - i)});
    start_op(1'b0, 1'b1);
    wait_done(-1);
    check("unf_n_wr", 32'(n_wr), 32'd4);
    check("unf_sp", 32'(sp), 32'd0);
    check_result("unf", 7, 1'b1, 2'b10, 4);
    check("unf_rf5_untouched", rf[5], 32'd0);

    // Both requests together: save wins; a restore pulse mid-save is ignored.
    rf_op(2'd1);
    stack_reset(32);
    load_exp_push(FW);
    start_op(1'b1, 1'b1);
    wait_done(3);
    check("both_n_pop", 32'(n_pop), 32'd0);
    check("both_n_push", 32'(n_push), 32'(FW));
    check_result("both", FW + 2, 1'b0, 2'b00, FW);
    repeat (2) @(negedge clk);
    check("both_idle_after", {31'b0, busy}, 32'd0);

    // Reset asserted during the fifth push.
    stack_reset(32);
    load_exp_push(5);
    start_op(1'b1, 1'b0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cyc - e_cyc + 1 == 5) break;
    end
    check("mid_fifth_push", {31'b0, stk_push}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_idle", {31'b0, busy}, 32'd0);
    check("post_reset_push_q", 32'(exp_push.size()), 32'd0);
    stack_reset(32);
    load_exp_push(FW);
    start_op(1'b1, 1'b0);
    wait_done(-1);
    check_result("post_reset_save", FW + 2, 1'b0, 2'b00, FW);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ctx_stack_sequencer.md
# ctx_stack_sequencer

Hardware context save/restore engine sitting between a core's register file and its port on the shared hardware stack controller. On a save request it pushes a fixed frame of FRAME_WORDS 32-bit words (PC, flags, general registers) onto the core's stack. On a restore request it pops the frame back in reverse order and writes it into the register file. Stack overflow and underflow abort the transfer, and the sequencer reports exactly how many words moved. One instance per core (RT and GP).

## Interface
- FRAME_WORDS, 10, words per context frame; legal range 2..32.
- AW (derived), $clog2(FRAME_WORDS), register-file index width.
- CW (derived), $clog2(FRAME_WORDS+1), transfer-count width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- save_req  in  1  start a save; sampled only in IDLE.
- restore_req  in  1  start a restore; sampled only in IDLE.
- busy  out  1  high in SAVE, SAVE_CHK, REST and REST_WB.
- done  out  1  one-cycle pulse on completion, both success and abort.
- err  out  1  last operation aborted; held until the next accepted request.
- err_code  out  2  00 none, 01 overflow, 10 underflow; held like err.
- xfer_count  out  CW  words successfully pushed or written by the last operation; held until the next accepted request.
- ctx_raddr  out  AW  register-file read index (combinational read).
- ctx_rdata  in  32  register-file read data for ctx_raddr, same cycle.
- ctx_we  out  1  register-file write strobe.
- ctx_waddr  out  AW  register-file write index.
- ctx_wdata  out  32  register-file write data.
- stk_push  out  1  push request to the stack controller.
- stk_pop  out  1  pop request to the stack controller.
- stk_wdata  out  32  push data.
- stk_rdata  in  32  pop data; valid the cycle after stk_pop.
- stk_overflow  in  1  registered flag; high the cycle after a rejected push.
- stk_underflow  in  1  registered flag; high the cycle after a rejected pop.

## Operation
States: IDLE, SAVE, SAVE_CHK, REST, REST_WB, DONE. Index counter idx has width CW.

- **IDLE**
  - save_req → SAVE; restore_req → REST.
  - If both are high, save wins.
  - On acceptance: idx=0, xfer_count=0, err=0, err_code=00.
- **SAVE** (cycle for index idx)
  - ctx_raddr=idx, stk_wdata=ctx_rdata.
  - stk_push = !stk_overflow (combinational gate).
  - If stk_overflow: no push, err=1, err_code=01, → DONE.
  - Else: xfer_count=idx (pushes 0..idx-1 confirmed). If idx==FRAME_WORDS-1 → SAVE_CHK; otherwise idx+1.
- **SAVE_CHK**
  - No push.
  - stk_overflow → err=1, err_code=01, xfer_count=FRAME_WORDS-1.
  - Else xfer_count=FRAME_WORDS.
  - → DONE.
- **REST** (cycle for index idx)
  - stk_pop = !stk_underflow; pops word FRAME_WORDS-1-idx.
  - If idx>0 and !stk_underflow: ctx_we=1, ctx_waddr=FRAME_WORDS-idx, ctx_wdata=stk_rdata, xfer_count+1.
  - If stk_underflow: no pop, no write, err=1, err_code=10, → DONE.
  - If idx==FRAME_WORDS-1 → REST_WB; otherwise idx+1.
- **REST_WB**
  - If !stk_underflow: write index 0 from stk_rdata, xfer_count+1.
  - Else err=1, err_code=10.
  - → DONE.
- **DONE**
  - done=1; → IDLE.
  - Requests presented in DONE are ignored.
- Requests while busy are ignored; nothing is queued.
- stk_push and stk_pop are never high in the same cycle.

## Timing
- Reset values: state IDLE. busy, done, err, ctx_we, stk_push, stk_pop = 0. err_code=00, xfer_count=0. ctx_raddr, ctx_waddr, ctx_wdata, stk_wdata = 0.
- All outputs are 0 outside their active states.
- Save: request accepted at edge E. Pushes occur in the FRAME_WORDS cycles after E. SAVE_CHK follows. done is high in cycle E+FRAME_WORDS+2.
- Restore: pops occur in FRAME_WORDS cycles, writes lag pops by one cycle. done is high in cycle E+FRAME_WORDS+2.
- Abort: DONE is entered the cycle after the flag is seen.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. Words already pushed or popped are not rolled back.

## Test plan
- Save, FRAME_WORDS=10, empty stack model, rdata[i]=0xA000_0000+i → 10 consecutive pushes of 0xA0000000..0xA0000009; done at cycle 12; err=0; xfer_count=10.
- Restore after that save, with the register file cleared → writes to indices 9..0 with matching values, one per cycle starting 1 cycle after the first pop; xfer_count=10; err=0.
- Save with the stack model holding 3 free slots → 3 accepted pushes; stk_push deasserted when stk_overflow rises; err=1; err_code=01; xfer_count=3; done pulses once.
- Restore with 4 words on the stack → writes to indices 9,8,7,6 only; no write after stk_underflow; err_code=10; xfer_count=4.
- save_req and restore_req high together in IDLE → save is performed. A restore_req pulse issued during SAVE is ignored (no pops).
- rst_n low at the 5th push → all outputs 0 asynchronously. After release, the sequencer stays in IDLE until a new request, and the following save runs normally.
